mul_ctrl: RTL and testbench

MUL_CTRL -- requirements
Module: mul_ctrl

---
 rtl/mul_ctrl_pkg.sv | 16 +
 rtl/mul_ctrl_cla.sv | 51 +++++
 rtl/mul_ctrl.sv | 133 +++++++++++++
 tb/tb_mul_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mul_ctrl_pkg.sv
// Shared types and sizing for the mul_ctrl Booth multiplier slice.
package mul_ctrl_pkg;

    localparam int MUL_WIDTH = 32;
    localparam int STEP_W    = 6;

    // Step counter value of the final Booth iteration.
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MUL_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_ctrl_cla.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups with a group-level carry chain.
module mul_ctrl_cla
    import mul_ctrl_pkg::*;
(
    input  logic [MUL_WIDTH-1:0] a,
    input  logic [MUL_WIDTH-1:0] b,
    input  logic                 cin,
    output logic [MUL_WIDTH-1:0] sum,
    output logic                 cout
);

    localparam int GROUPS = MUL_WIDTH / 4;

    logic [MUL_WIDTH-1:0] g;
    logic [MUL_WIDTH-1:0] p;
    logic [MUL_WIDTH-1:0] c;
    logic [GROUPS-1:0]    gg;
    logic [GROUPS-1:0]    gp;
    logic [GROUPS:0]      gc;

    assign g = a & b;
    assign p = a ^ b;

    // NOTE: every variable written here gets a value on every pass first; a path that
    // skips an assignment would infer a latch.
    always_comb begin
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        gc[0] = cin;
        for (int j = 0; j < GROUPS; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
            gc[j+1] = gg[j] | (gp[j] & gc[j]);

            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
    end

    assign sum  = p ^ c;
    assign cout = gc[GROUPS];

endmodule

// File: rtl/mul_ctrl.sv
// Sequential radix-2 Booth signed 32x32 multiplier: one load cycle, 32 add/shift steps.
// Optional build macro MUL_CTRL_ZERO_BYPASS_EN: a zero operand goes straight to DONE.
module mul_ctrl
    import mul_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [MUL_WIDTH-1:0] multiplicand,
    input  logic [MUL_WIDTH-1:0] multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [MUL_WIDTH-1:0] hi,
    output logic [MUL_WIDTH-1:0] lo
);

    state_t               state;
    state_t               state_nx;
    logic [MUL_WIDTH-1:0] m_reg;
    logic [MUL_WIDTH-1:0] a_reg;
    logic [MUL_WIDTH-1:0] q_reg;
    logic                 q_m1;
    logic [STEP_W-1:0]    step;
    logic [MUL_WIDTH-1:0] hi_reg;
    logic [MUL_WIDTH-1:0] lo_reg;

    logic                 add_en;
    logic                 sub_en;
    logic [MUL_WIDTH-1:0] add_b;
    logic [MUL_WIDTH-1:0] sum;
    logic                 cout;
    logic [MUL_WIDTH-1:0] a_sel;
    logic                 sign_in;
    logic [MUL_WIDTH-1:0] a_shift;
    logic [MUL_WIDTH-1:0] q_shift;
    logic                 last_step;
    logic                 zero_op;

`ifdef MUL_CTRL_ZERO_BYPASS_EN
    assign zero_op = (multiplicand == '0) || (multiplier == '0);
`else
    assign zero_op = 1'b0;
`endif

    assign add_en    = ({q_reg[0], q_m1} == 2'b01);
    assign sub_en    = ({q_reg[0], q_m1} == 2'b10);
    assign add_b     = sub_en ? ~m_reg : (add_en ? m_reg : '0);
    assign last_step = (step == LAST_STEP);

    mul_ctrl_cla u_cla (
        .a    (a_reg),
        .b    (add_b),
        .cin  (sub_en),
        .sum  (sum),
        .cout (cout)
    );

    // The shifted-in sign is the true 33rd sum bit, so M = -2^31 cannot overflow A.
    always_comb begin
        a_sel   = a_reg;
        sign_in = a_reg[MUL_WIDTH-1];
        if (add_en || sub_en) begin
            a_sel   = sum;
            sign_in = a_reg[MUL_WIDTH-1] ^ add_b[MUL_WIDTH-1] ^ cout;
        end
        a_shift = {sign_in, a_sel[MUL_WIDTH-1:1]};
        q_shift = {a_sel[0], q_reg[MUL_WIDTH-1:1]};
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = zero_op ? DONE : RUN;
            RUN:     if (last_step) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // hi/lo are captured on the edge into DONE so they are valid alongside done and
    // survive the next operation clearing A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reg  <= '0;
            a_reg  <= '0;
            q_reg  <= '0;
            q_m1   <= 1'b0;
            step   <= '0;
            hi_reg <= '0;
            lo_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m_reg <= multiplicand;
                        q_reg <= multiplier;
                        a_reg <= '0;
                        q_m1  <= 1'b0;
                        step  <= '0;
                        if (zero_op) begin
                            hi_reg <= '0;
                            lo_reg <= '0;
                        end
                    end
                end
                RUN: begin
                    a_reg <= a_shift;
                    q_reg <= q_shift;
                    q_m1  <= q_reg[0];
                    step  <= step + 1'b1;
                    if (last_step) begin
                        hi_reg <= a_shift;
                        lo_reg <= q_shift;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_mul_ctrl.sv
// Self-checking bench for mul_ctrl: vector table plus multi-cycle corner sequences.
module tb_mul_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef MUL_CTRL_ZERO_BYPASS_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 33;
`endif
    localparam int FULL_LAT = 33;

    mul_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .hi           (hi),
        .lo           (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] m;
        logic [31:0] q;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the done cycle.
    task automatic run_op(input logic [31:0] m, input logic [31:0] q,
                          output logic [31:0] r_hi, output logic [31:0] r_lo,
                          output int lat, output logic busy1);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = -1;
        busy1 = busy;
        r_hi  = 'x;
        r_lo  = 'x;
        for (int c = 1; c <= 100; c++) begin
            if (done) begin
                lat  = c;
                r_hi = hi;
                r_lo = lo;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] r_hi;
        logic [31:0] r_lo;
        int          lat;
        logic        busy1;
        int          n_done;
        int          first_done;
        logic [31:0] cap_hi;
        logic [31:0] cap_lo;

        vecs[0]  = '{32'd6,        32'd7,        32'h0000_0000, 32'h0000_002A};
        vecs[1]  = '{32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2]  = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[3]  = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000};
        vecs[4]  = '{32'd0,        32'd123,      32'h0000_0000, 32'h0000_0000};
        vecs[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[6]  = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001};
        vecs[7]  = '{32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
        vecs[8]  = '{32'd100000,   32'hFFFE_7960, 32'hFFFF_FFFD, 32'hABF4_1C00};
        vecs[9]  = '{32'h8000_0000, 32'd1,        32'hFFFF_FFFF, 32'h8000_0000};
        vecs[10] = '{32'd123,      32'd0,        32'h0000_0000, 32'h0000_0000};

        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(negedge clk);
        check("reset state", {30'd0, busy, done, hi, lo}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            int exp_lat;
            exp_lat = (vecs[i].m == 0 || vecs[i].q == 0) ? ZERO_LAT : FULL_LAT;
            run_op(vecs[i].m, vecs[i].q, r_hi, r_lo, lat, busy1);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(exp_lat));
            check($sformatf("vec%0d hi", i), {32'd0, r_hi}, {32'd0, vecs[i].exp_hi});
            check($sformatf("vec%0d lo", i), {32'd0, r_lo}, {32'd0, vecs[i].exp_lo});
            check($sformatf("vec%0d busy after start", i), {63'd0, busy1}, 64'd1);
            check($sformatf("vec%0d idle hold", i), {busy, done, 30'd0, hi ^ vecs[i].exp_hi},
                  64'd0);
            check($sformatf("vec%0d lo hold", i), {32'd0, lo}, {32'd0, vecs[i].exp_lo});
        end

        // start pulses and operand changes while busy must not disturb the first operation
        multiplicand = 32'd6;
        multiplier   = 32'd7;
        start        = 1'b1;
        @(negedge clk);
        n_done     = 0;
        first_done = -1;
        cap_hi     = 'x;
        cap_lo     = 'x;
        for (int c = 1; c <= 45; c++) begin
            if (done) begin
                n_done++;
                if (first_done < 0) begin
                    first_done = c;
                    cap_hi     = hi;
                    cap_lo     = lo;
                end
            end
            if (c == 5 || c == 12 || c == 20) begin
                start        = 1'b1;
                multiplicand = 32'd9 + 32'(c);
                multiplier   = 32'd11;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check("busy-start done count", 64'(n_done), 64'd1);
        check("busy-start latency", 64'(first_done), 64'(FULL_LAT));
        check("busy-start result", {cap_hi, cap_lo}, 64'h0000_0000_0000_002A);

        // leave a nonzero result so the asynchronous clear is visible
        run_op(32'hFFFF_FFFD, 32'd5, r_hi, r_lo, lat, busy1);
        check("pre-reset result", {r_hi, r_lo}, 64'hFFFF_FFFF_FFFF_FFF1);

        multiplicand = 32'd6;
        multiplier   = 32'd7;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async reset clear", {30'd0, busy, done, hi, lo}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        check("no done after abort", 64'(n_done), 64'd0);

        run_op(32'd6, 32'd7, r_hi, r_lo, lat, busy1);
        check("post-reset latency", 64'(lat), 64'(FULL_LAT));
        check("post-reset result", {r_hi, r_lo}, 64'h0000_0000_0000_002A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
